// File: rtl/jac_pkg.sv
// Shared encodings for the Jac1-8 instruction set: opcodes, status bit indices,
// register-input mux codes, instruction field positions and decoder FSM states.
package jac_pkg;

    localparam int OPC_WIDTH   = 5;
    localparam int OPC_LSB     = 11;
    localparam int OP1_LSB     = 8;
    localparam int OP2_LSB     = 3;
    localparam int PARAM_LSB   = 0;
    localparam int PARAM_WIDTH = 8;

    localparam logic [OPC_WIDTH-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPC_WIDTH-1:0] OP_ADD  = 5'b00001;
    localparam logic [OPC_WIDTH-1:0] OP_SUB  = 5'b00010;
    localparam logic [OPC_WIDTH-1:0] OP_AND  = 5'b00011;
    localparam logic [OPC_WIDTH-1:0] OP_OR   = 5'b00100;
    localparam logic [OPC_WIDTH-1:0] OP_XOR  = 5'b00101;
    localparam logic [OPC_WIDTH-1:0] OP_NOT  = 5'b00110;
    localparam logic [OPC_WIDTH-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPC_WIDTH-1:0] OP_SHR  = 5'b01000;
    localparam logic [OPC_WIDTH-1:0] OP_VAL  = 5'b01001;
    localparam logic [OPC_WIDTH-1:0] OP_CMPR = 5'b01010;
    localparam logic [OPC_WIDTH-1:0] OP_GOTO = 5'b10000;
    localparam logic [OPC_WIDTH-1:0] OP_IFZ  = 5'b10001;
    localparam logic [OPC_WIDTH-1:0] OP_IFNZ = 5'b10010;
    localparam logic [OPC_WIDTH-1:0] OP_IFEQ = 5'b10011;
    localparam logic [OPC_WIDTH-1:0] OP_IFST = 5'b10100;
    localparam logic [OPC_WIDTH-1:0] OP_IFGT = 5'b10101;
    localparam logic [OPC_WIDTH-1:0] OP_CALL = 5'b10110;
    localparam logic [OPC_WIDTH-1:0] OP_RET  = 5'b10111;

    localparam int ST_CARRY     = 0;
    localparam int ST_UNDERFLOW = 1;
    localparam int ST_ZERO      = 2;
    localparam int ST_EQUAL     = 3;
    localparam int ST_GREATER   = 4;
    localparam int ST_SMALLER   = 5;

    localparam logic SEL_DECODER = 1'b0;
    localparam logic SEL_ALU     = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STALL} state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for CALL/RET. Push on full and pop on empty are ignored;
// top is only meaningful while the stack is not empty.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] top
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
    localparam logic [AW:0] ONE     = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      sp;
    logic [AW:0]      sp_dec;

    assign sp_dec = sp - ONE;
    assign full   = (sp == DEPTH_V);
    assign empty  = (sp == '0);
    assign top    = mem[sp_dec[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[sp[AW-1:0]] <= push_data;
            sp              <= sp + ONE;
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end
endmodule

// File: rtl/seq_decoder.sv
// Registered, handshaked Jac1-8 decoder with CALL/RET support. One instruction per
// accept; strobes pulse in the following (ISSUE) cycle, selects hold until the next accept.
module seq_decoder
    import jac_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SEL_WIDTH   = 2,
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int NUM_STATUS  = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [NUM_STATUS-1:0]  status,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   ex_busy,
    output logic [OPC_WIDTH-1:0]   opcode,
    output logic [DATA_WIDTH-1:0]  param,
    output logic [PC_WIDTH-1:0]    literal_adr,
    output logic [SEL_WIDTH-1:0]   rd_sel1,
    output logic [SEL_WIDTH-1:0]   rd_sel2,
    output logic                   rd_en1,
    output logic                   rd_en2,
    output logic                   wr_en,
    output logic [SEL_WIDTH-1:0]   wr_sel,
    output logic                   sel_reg_in_alu_decoder,
    output logic                   stat_wr_en,
    output logic                   cnt_wr_en,
    output logic                   add_offset,
    output logic                   stack_err
);
    state_t state, state_next;
    logic   accept;

    logic [OPC_WIDTH-1:0]   d_opc;
    logic [PARAM_WIDTH-1:0] d_param8;
    logic [SEL_WIDTH-1:0]   op1, op2;
    logic [SEL_WIDTH-1:0]   d_rd_sel1, d_rd_sel2;
    logic                   d_rd_en1, d_rd_en2, d_wr_en, d_sel, d_stat, d_cnt, d_add;
    logic                   d_push, d_pop, d_err;
    logic [PC_WIDTH-1:0]    d_lit;

    logic                   stk_full, stk_empty;
    logic [PC_WIDTH-1:0]    stk_top;
    logic                   unused_bits;

    assign d_opc    = instr[OPC_LSB +: OPC_WIDTH];
    assign d_param8 = instr[PARAM_LSB +: PARAM_WIDTH];
    assign op1      = instr[OP1_LSB +: SEL_WIDTH];
    assign op2      = instr[OP2_LSB +: SEL_WIDTH];
    assign unused_bits = ^{instr, status};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (accept) state_next = S_ISSUE;
            S_ISSUE: state_next = ex_busy ? S_STALL : S_IDLE;
            S_STALL: if (!ex_busy) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        accept      = instr_valid && instr_ready;
    end

    // Decode straight from the input word; the output register then acts as the capture stage.
    always_comb begin
        d_rd_en1  = 1'b0;
        d_rd_en2  = 1'b0;
        d_rd_sel1 = '0;
        d_rd_sel2 = '0;
        d_wr_en   = 1'b0;
        d_sel     = SEL_DECODER;
        d_stat    = 1'b0;
        d_cnt     = 1'b0;
        d_add     = 1'b0;
        d_push    = 1'b0;
        d_pop     = 1'b0;
        d_err     = 1'b0;
        d_lit     = PC_WIDTH'(d_param8);
        case (d_opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                d_rd_en1 = 1'b1; d_rd_sel1 = op1;
                d_rd_en2 = 1'b1; d_rd_sel2 = op2;
                d_sel = SEL_ALU; d_wr_en = 1'b1; d_stat = 1'b1;
            end
            OP_NOT: begin
                d_rd_en2 = 1'b1; d_rd_sel2 = op2;
                d_sel = SEL_ALU; d_wr_en = 1'b1; d_stat = 1'b1;
            end
            OP_SHL, OP_SHR: begin
                d_rd_en1 = 1'b1; d_rd_sel1 = op1;
                d_sel = SEL_ALU; d_wr_en = 1'b1; d_stat = 1'b1;
            end
            OP_VAL:  d_wr_en = 1'b1;
            OP_CMPR: begin
                d_rd_en1 = 1'b1; d_rd_sel1 = op1;
                d_rd_en2 = 1'b1; d_rd_sel2 = op2;
                d_sel = SEL_ALU; d_stat = 1'b1;
            end
            OP_GOTO: d_cnt = 1'b1;
            OP_IFZ:  begin d_cnt = status[ST_ZERO];     d_add = d_cnt; end
            OP_IFNZ: begin d_cnt = !status[ST_ZERO];    d_add = d_cnt; end
            OP_IFEQ: begin d_cnt = status[ST_EQUAL];    d_add = d_cnt; end
            OP_IFST: begin d_cnt = status[ST_SMALLER];  d_add = d_cnt; end
            OP_IFGT: begin d_cnt = status[ST_GREATER];  d_add = d_cnt; end
            OP_CALL: begin
                d_push = !stk_full;
                d_cnt  = !stk_full;
                d_err  = stk_full;
            end
            OP_RET: begin
                d_pop = !stk_empty;
                d_cnt = !stk_empty;
                d_err = stk_empty;
                d_lit = stk_empty ? '0 : stk_top;
            end
            default: ;
        endcase
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (accept && d_push),
        .pop       (accept && d_pop),
        .push_data (pc_in + PC_WIDTH'(1)),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode                 <= '0;
            param                  <= '0;
            literal_adr            <= '0;
            rd_sel1                <= '0;
            rd_sel2                <= '0;
            rd_en1                 <= 1'b0;
            rd_en2                 <= 1'b0;
            wr_sel                 <= '0;
            sel_reg_in_alu_decoder <= 1'b0;
            wr_en                  <= 1'b0;
            stat_wr_en             <= 1'b0;
            cnt_wr_en              <= 1'b0;
            add_offset             <= 1'b0;
            stack_err              <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            stat_wr_en <= 1'b0;
            cnt_wr_en  <= 1'b0;
            add_offset <= 1'b0;
            if (accept) begin
                opcode                 <= d_opc;
                param                  <= DATA_WIDTH'(d_param8);
                literal_adr            <= d_lit;
                rd_sel1                <= d_rd_sel1;
                rd_sel2                <= d_rd_sel2;
                rd_en1                 <= d_rd_en1;
                rd_en2                 <= d_rd_en2;
                wr_sel                 <= op1;
                sel_reg_in_alu_decoder <= d_sel;
                wr_en                  <= d_wr_en;
                stat_wr_en             <= d_stat;
                cnt_wr_en              <= d_cnt;
                add_offset             <= d_add;
                if (d_err) stack_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder: a reference decode/stack model queues the expected
// ISSUE-cycle outputs at each accept; they are popped and compared one cycle later.
module tb_seq_decoder;

    localparam logic [4:0] O_NOP = 5'b00000, O_ADD = 5'b00001, O_SUB = 5'b00010, O_AND = 5'b00011;
    localparam logic [4:0] O_OR = 5'b00100, O_XOR = 5'b00101, O_NOT = 5'b00110, O_SHL = 5'b00111;
    localparam logic [4:0] O_SHR = 5'b01000, O_VAL = 5'b01001, O_CMPR = 5'b01010, O_GOTO = 5'b10000;
    localparam logic [4:0] O_IFZ = 5'b10001, O_IFNZ = 5'b10010, O_IFEQ = 5'b10011, O_IFST = 5'b10100;
    localparam logic [4:0] O_IFGT = 5'b10101, O_CALL = 5'b10110, O_RET = 5'b10111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [5:0]  status = '0;
    logic [7:0]  pc_in = '0;
    logic        ex_busy = 1'b0;
    logic [4:0]  opcode;
    logic [7:0]  param, literal_adr;
    logic [1:0]  rd_sel1, rd_sel2, wr_sel;
    logic        rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder, stat_wr_en, cnt_wr_en, add_offset;
    logic        stack_err;

    seq_decoder #(
        .DATA_WIDTH (8), .SEL_WIDTH (2), .PC_WIDTH (8),
        .INSTR_WIDTH (16), .NUM_STATUS (6), .STACK_DEPTH (4)
    ) dut (
        .clk (clk), .reset (reset), .instr (instr), .instr_valid (instr_valid),
        .instr_ready (instr_ready), .status (status), .pc_in (pc_in), .ex_busy (ex_busy),
        .opcode (opcode), .param (param), .literal_adr (literal_adr),
        .rd_sel1 (rd_sel1), .rd_sel2 (rd_sel2), .rd_en1 (rd_en1), .rd_en2 (rd_en2),
        .wr_en (wr_en), .wr_sel (wr_sel), .sel_reg_in_alu_decoder (sel_reg_in_alu_decoder),
        .stat_wr_en (stat_wr_en), .cnt_wr_en (cnt_wr_en), .add_offset (add_offset),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] opc;
        logic [7:0] prm;
        logic [7:0] lit;
        logic [1:0] rs1, rs2, ws;
        logic       re1, re2, we, sel, st, cnt, add, err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rstk[$];
    logic       err_m = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [4:0] o, input logic [1:0] a, input logic [7:0] lo);
        return {o, 1'b0, a, lo};
    endfunction

    task automatic predict(input logic [15:0] ins, input logic [5:0] st, input logic [7:0] pc);
        exp_t e;
        logic [4:0] o;
        logic [1:0] a, b;
        logic [7:0] p;
        logic take;
        o = ins[15:11]; a = ins[9:8]; p = ins[7:0]; b = p[4:3];
        e = '0;
        e.opc = o; e.prm = p; e.lit = p; e.ws = a;
        take = 1'b0;
        case (o)
            O_ADD, O_SUB, O_AND, O_OR, O_XOR: begin
                e.re1 = 1; e.rs1 = a; e.re2 = 1; e.rs2 = b; e.sel = 1; e.we = 1; e.st = 1;
            end
            O_NOT:        begin e.re2 = 1; e.rs2 = b; e.sel = 1; e.we = 1; e.st = 1; end
            O_SHL, O_SHR: begin e.re1 = 1; e.rs1 = a; e.sel = 1; e.we = 1; e.st = 1; end
            O_VAL:        e.we = 1;
            O_CMPR:       begin e.re1 = 1; e.rs1 = a; e.re2 = 1; e.rs2 = b; e.sel = 1; e.st = 1; end
            O_GOTO:       e.cnt = 1;
            O_IFZ:        take = st[2];
            O_IFNZ:       take = !st[2];
            O_IFEQ:       take = st[3];
            O_IFST:       take = st[5];
            O_IFGT:       take = st[4];
            O_CALL: begin
                if (rstk.size() < 4) begin rstk.push_back(pc + 8'd1); e.cnt = 1; end
                else err_m = 1'b1;
            end
            O_RET: begin
                if (rstk.size() > 0) begin e.lit = rstk.pop_back(); e.cnt = 1; end
                else begin err_m = 1'b1; e.lit = 8'h00; end
            end
            default: ;
        endcase
        if (take) begin e.cnt = 1; e.add = 1; end
        e.err = err_m;
        sb.push_back(e);
    endtask

    task automatic compare_issue(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".opcode"}, opcode, e.opc);
        check({tag, ".param"}, param, e.prm);
        check({tag, ".literal_adr"}, literal_adr, e.lit);
        check({tag, ".rd"}, {rd_en1, rd_sel1, rd_en2, rd_sel2}, {e.re1, e.rs1, e.re2, e.rs2});
        check({tag, ".wr"}, {wr_en, wr_sel, sel_reg_in_alu_decoder}, {e.we, e.ws, e.sel});
        check({tag, ".strobes"}, {stat_wr_en, cnt_wr_en, add_offset}, {e.st, e.cnt, e.add});
        check({tag, ".stack_err"}, stack_err, e.err);
        check({tag, ".ready_issue"}, instr_ready, 1'b0);
    endtask

    task automatic check_quiet(input string tag, input logic ready_want);
        check({tag, ".strobes_off"}, {wr_en, stat_wr_en, cnt_wr_en, add_offset}, 4'b0000);
        check({tag, ".ready"}, instr_ready, ready_want);
    endtask

    task automatic send(input string tag, input logic [15:0] ins, input logic [5:0] st,
                        input logic [7:0] pc, input int busy);
        int n;
        @(negedge clk);
        instr = ins; status = st; pc_in = pc; instr_valid = 1'b1; ex_busy = 1'b0;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, ".ready_wait"}, instr_ready, 1'b1);
        predict(ins, st, pc);
        if (busy > 0) ex_busy = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = '0;
        compare_issue(tag);
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            check_quiet({tag, ".stall"}, 1'b0);
        end
        ex_busy = 1'b0;
        @(negedge clk);
        check_quiet({tag, ".idle"}, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_valid = 1'b0; ex_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rstk.delete(); sb.delete(); err_m = 1'b0;
        @(negedge clk);
        check("rst.ready", instr_ready, 1'b1);
        check("rst.fields", {opcode, param, literal_adr}, '0);
        check("rst.sels", {rd_sel1, rd_sel2, wr_sel, rd_en1, rd_en2, sel_reg_in_alu_decoder}, '0);
        check("rst.strobes", {wr_en, stat_wr_en, cnt_wr_en, add_offset, stack_err}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        send("add",  mk(O_ADD, 2'b01, 8'h10), 6'h00, 8'h00, 0);
        send("sub",  mk(O_SUB, 2'b10, 8'h08), 6'h00, 8'h01, 0);
        send("and",  mk(O_AND, 2'b11, 8'h00), 6'h00, 8'h02, 0);
        send("or",   mk(O_OR,  2'b00, 8'h18), 6'h00, 8'h03, 0);
        send("xor",  mk(O_XOR, 2'b01, 8'h08), 6'h00, 8'h04, 0);
        send("not",  mk(O_NOT, 2'b11, 8'h18), 6'h00, 8'h05, 0);
        send("shl",  mk(O_SHL, 2'b01, 8'h18), 6'h00, 8'h06, 0);
        send("shr",  mk(O_SHR, 2'b10, 8'h10), 6'h00, 8'h07, 0);
        send("val",  mk(O_VAL, 2'b10, 8'hA5), 6'h00, 8'h08, 0);
        send("cmpr", mk(O_CMPR, 2'b11, 8'h08), 6'h3F, 8'h09, 0);
        send("nop",  mk(O_NOP, 2'b01, 8'h10), 6'h3F, 8'h0A, 0);
        send("rsvd", mk(5'b11000, 2'b10, 8'h5A), 6'h3F, 8'h0B, 0);
        send("goto", mk(O_GOTO, 2'b00, 8'h20), 6'h00, 8'h0C, 0);
        send("ifz1",  mk(O_IFZ,  2'b00, 8'h09), 6'b000100, 8'h0D, 0);
        send("ifz0",  mk(O_IFZ,  2'b00, 8'h09), 6'b111011, 8'h0E, 0);
        send("ifnz1", mk(O_IFNZ, 2'b00, 8'h05), 6'b000000, 8'h0F, 0);
        send("ifnz0", mk(O_IFNZ, 2'b00, 8'h05), 6'b000100, 8'h10, 0);
        send("ifeq1", mk(O_IFEQ, 2'b00, 8'h0F), 6'b001000, 8'h11, 0);
        send("ifeq0", mk(O_IFEQ, 2'b00, 8'h0F), 6'b110111, 8'h12, 0);
        send("ifst1", mk(O_IFST, 2'b00, 8'hF0), 6'b100000, 8'h13, 0);
        send("ifst0", mk(O_IFST, 2'b00, 8'hF0), 6'b011111, 8'h14, 0);
        send("ifgt1", mk(O_IFGT, 2'b00, 8'h33), 6'b010000, 8'h15, 0);
        send("ifgt0", mk(O_IFGT, 2'b00, 8'h33), 6'b101111, 8'h16, 0);

        send("call", mk(O_CALL, 2'b00, 8'h3F), 6'h00, 8'h10, 0);
        send("ret",  mk(O_RET,  2'b00, 8'h00), 6'h00, 8'h40, 0);
        send("callwrap", mk(O_CALL, 2'b00, 8'h01), 6'h00, 8'hFF, 0);
        send("retwrap",  mk(O_RET,  2'b00, 8'h00), 6'h00, 8'h02, 0);

        send("busy", mk(O_ADD, 2'b10, 8'h08), 6'h00, 8'h20, 3);

        do_reset();
        for (int i = 0; i < 5; i++)
            send("callfull", mk(O_CALL, 2'b00, 8'h30 + 8'(i)), 6'h00, 8'h50 + 8'(i), 0);
        send("errsticky", mk(O_NOP, 2'b00, 8'h00), 6'h00, 8'h60, 0);
        for (int i = 0; i < 4; i++)
            send("retpop", mk(O_RET, 2'b00, 8'h00), 6'h00, 8'h70, 0);
        do_reset();
        send("retempty", mk(O_RET, 2'b00, 8'h00), 6'h00, 8'h71, 0);

        do_reset();
        send("precall", mk(O_CALL, 2'b00, 8'h44), 6'h00, 8'h80, 0);
        @(negedge clk);
        instr = mk(O_ADD, 2'b11, 8'h18); instr_valid = 1'b1;
        predict(instr, 6'h00, 8'h81);
        @(negedge clk);
        instr_valid = 1'b0;
        compare_issue("midrst");
        reset = 1'b1;
        @(negedge clk);
        check("midrst.strobes", {wr_en, stat_wr_en, cnt_wr_en, add_offset}, 4'b0000);
        check("midrst.fields", {opcode, wr_sel, rd_en1, rd_en2}, '0);
        reset = 1'b0;
        rstk.delete(); sb.delete(); err_m = 1'b0;
        send("midrst_ret", mk(O_RET, 2'b00, 8'h00), 6'h00, 8'h90, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
